// File: rtl/adc_pkg.sv
// Shared types and CSR constants for the adc sample reader.
package adc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG_RUN,
        ST_CFG_IRQ,
        ST_WAIT_IRQ,
        ST_READ,
        ST_READ_WAIT,
        ST_CLEAR,
        ST_GUARD,
        ST_STOP
    } adc_rd_state_t;

    localparam logic            ADC_SEQ_CMD_ADDR  = 1'b0;
    localparam logic [6:0]      ADC_IRQ_EN_ADDR   = 7'h40;
    localparam logic [6:0]      ADC_IRQ_STAT_ADDR = 7'h41;
    localparam logic [31:0]     ADC_SEQ_RUN       = 32'h1;
    localparam int unsigned     ADC_SAMPLE_W      = 12;
    localparam int unsigned     ADC_SLOT_W        = 4;
    localparam int unsigned     ADC_ENTRY_W       = ADC_SLOT_W + ADC_SAMPLE_W;
    localparam int unsigned     ADC_CSR_ADDR_W    = 7;
    localparam int unsigned     ADC_CSR_DATA_W    = 32;

    // One FIFO entry: the slot a sample came from and the sample itself.
    typedef struct packed {
        logic [ADC_SLOT_W-1:0]   slot;
        logic [ADC_SAMPLE_W-1:0] sample;
    } adc_entry_t;

endpackage

// File: rtl/adc_sample_reader_if.sv
// Avalon-MM CSR signals shared by the adc sequencer and sample-store ports.
interface adc_sample_reader_if;
    import adc_pkg::*;

    logic                      sequencerAddress;
    logic                      sequencerRead;
    logic                      sequencerWrite;
    logic [ADC_CSR_DATA_W-1:0] adcDataIn;
    logic [ADC_CSR_ADDR_W-1:0] sampleAddress;
    logic                      sampleRead;
    logic                      sampleWrite;
    logic [ADC_CSR_DATA_W-1:0] sampleDataOut;
    logic                      sampleValid;
    logic                      sampleIrq;

    modport master (
        output sequencerAddress, sequencerRead, sequencerWrite, adcDataIn,
        output sampleAddress, sampleRead, sampleWrite,
        input  sampleDataOut, sampleValid, sampleIrq
    );

    modport slave (
        input  sequencerAddress, sequencerRead, sequencerWrite, adcDataIn,
        input  sampleAddress, sampleRead, sampleWrite,
        output sampleDataOut, sampleValid, sampleIrq
    );

endinterface

// File: rtl/adc_sample_fifo.sv
// Synchronous first-word-fall-through FIFO; head is valid whenever not empty.
module adc_sample_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             pop_ok_c;
    logic             push_ok_c;

    assign full_c    = (count == CNT_W'(DEPTH));
    assign empty_c   = (count == '0);
    assign pop_ok_c  = pop && !empty_c;
    // A pop frees a slot in the same cycle, so push into a full FIFO still lands.
    assign push_ok_c = push && (!full_c || pop_ok_c);
    assign head_c    = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok_c, pop_ok_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only observed through the valid head.
    always_ff @(posedge clk) begin
        if (push_ok_c) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/adc_sample_reader.sv
// Starts the adc sequencer, then drains SLOTS sample-store slots into a FIFO per IRQ.
module adc_sample_reader
    import adc_pkg::*;
#(
    parameter int unsigned SLOTS      = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    output logic                   busy,
    adc_sample_reader_if.master    bus,
    output logic [ADC_ENTRY_W-1:0] fifoData,
    output logic                   fifoValid,
    input  logic                   fifoRead,
    output logic                   overflow,
    input  logic                   overflowClear
);

    adc_rd_state_t         state;
    logic [ADC_SLOT_W-1:0] slot;
    logic                  last_slot_c;
    logic                  push_c;
    logic                  drop_c;
    adc_entry_t            entry_c;
    logic [ADC_ENTRY_W-1:0] head_c;
    logic                  full_c;
    logic                  empty_c;
    logic                  unused_upper_c;

    assign last_slot_c    = (slot == ADC_SLOT_W'(SLOTS - 1));
    assign push_c         = (state == ST_READ_WAIT) && bus.sampleValid;
    assign entry_c.slot   = slot;
    assign entry_c.sample = bus.sampleDataOut[ADC_SAMPLE_W-1:0];
    // A push into a full FIFO with no simultaneous pop loses the sample.
    assign drop_c         = push_c && full_c && !fifoRead;
    assign unused_upper_c = ^bus.sampleDataOut[ADC_CSR_DATA_W-1:ADC_SAMPLE_W];

    assign bus.sequencerRead = 1'b0;
    assign fifoValid         = !empty_c;
    assign fifoData          = fifoValid ? head_c : '0;

    adc_sample_fifo #(
        .WIDTH (ADC_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .push_data (entry_c),
        .pop       (fifoRead),
        .head_c    (head_c),
        .full_c    (full_c),
        .empty_c   (empty_c)
    );

    // Acquisition FSM; strobes for the next state are registered alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= ST_IDLE;
            slot                 <= '0;
            busy                 <= 1'b0;
            bus.sequencerAddress <= ADC_SEQ_CMD_ADDR;
            bus.sequencerWrite   <= 1'b0;
            bus.adcDataIn        <= '0;
            bus.sampleAddress    <= '0;
            bus.sampleRead       <= 1'b0;
            bus.sampleWrite      <= 1'b0;
        end else begin
            bus.sequencerAddress <= ADC_SEQ_CMD_ADDR;
            bus.sequencerWrite   <= 1'b0;
            bus.adcDataIn        <= '0;
            bus.sampleAddress    <= '0;
            bus.sampleRead       <= 1'b0;
            bus.sampleWrite      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state              <= ST_CFG_RUN;
                        busy               <= 1'b1;
                        bus.sequencerWrite <= 1'b1;
                        bus.adcDataIn      <= ADC_SEQ_RUN;
                    end
                end
                ST_CFG_RUN: begin
                    state             <= ST_CFG_IRQ;
                    bus.sampleWrite   <= 1'b1;
                    bus.sampleAddress <= ADC_IRQ_EN_ADDR;
                    bus.adcDataIn     <= 32'h1;
                end
                ST_CFG_IRQ: begin
                    state <= ST_WAIT_IRQ;
                end
                ST_WAIT_IRQ: begin
                    // Stop request outranks a pending IRQ.
                    if (!enable) begin
                        state              <= ST_STOP;
                        bus.sequencerWrite <= 1'b1;
                        bus.adcDataIn      <= '0;
                    end else if (bus.sampleIrq) begin
                        state             <= ST_READ;
                        slot              <= '0;
                        bus.sampleRead    <= 1'b1;
                        bus.sampleAddress <= '0;
                    end
                end
                ST_READ: begin
                    state <= ST_READ_WAIT;
                end
                ST_READ_WAIT: begin
                    if (bus.sampleValid) begin
                        if (last_slot_c) begin
                            state             <= ST_CLEAR;
                            bus.sampleWrite   <= 1'b1;
                            bus.sampleAddress <= ADC_IRQ_STAT_ADDR;
                            bus.adcDataIn     <= 32'h1;
                        end else begin
                            state             <= ST_READ;
                            slot              <= slot + ADC_SLOT_W'(1);
                            bus.sampleRead    <= 1'b1;
                            bus.sampleAddress <= ADC_CSR_ADDR_W'(slot + ADC_SLOT_W'(1));
                        end
                    end
                end
                ST_CLEAR: begin
                    state <= ST_GUARD;
                end
                ST_GUARD: begin
                    // IRQ line still falling after the acknowledge; skip one cycle.
                    state <= ST_WAIT_IRQ;
                end
                ST_STOP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop_c) begin
            overflow <= 1'b1;
        end else if (overflowClear) begin
            overflow <= 1'b0;
        end
    end

endmodule
